// File: rtl/digilock_pkg.sv
// Shared types and constants for the digilock keypad code-entry block.
package digilock_pkg;

  localparam int CODE_W  = 16;
  localparam int DIGIT_W = 4;
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/digilock_timer.sv
// Loadable down-counter; o_done is high during the last counted cycle.
module digilock_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  // Counter reaches zero on the edge that ends this cycle.
  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/digilock_code_entry.sv
// Keypad code-entry FSM: collects 4 BCD digits, checks them against an
// external comparator and handles retry counting and timed lockout.
module digilock_code_entry
  import digilock_pkg::*;
#(
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_valid,
  input  logic               clear,
  input  logic               enter,
  input  logic               match,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  output logic [2:0]         digit_count,
  output logic               unlocked,
  output logic               error,
  output logic               locked_out
);

  localparam logic [3:0]  TRY_LIMIT = 4'(MAX_TRIES);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES);

  state_t              r_state, w_state_nxt;
  logic [CODE_W-1:0]   r_code, w_code_nxt;
  logic [2:0]          r_count, w_count_nxt;
  logic [2:0]          r_tries, w_tries_nxt;
  logic                r_err, w_err_nxt;
  logic                w_tmr_load, w_tmr_done;
  logic [3:0]          w_tries_inc;
  logic                w_digit_ok;

  assign w_tries_inc = {1'b0, r_tries} + 4'd1;
  assign w_digit_ok  = digit_valid && is_bcd(digit) && (r_count < MAX_DIGITS);

  digilock_timer #(.W(16)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (LOCK_LOAD),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_count <= '0;
      r_tries <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_count <= w_count_nxt;
      r_tries <= w_tries_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_count_nxt = r_count;
    w_tries_nxt = r_tries;
    w_err_nxt   = 1'b0;
    w_tmr_load  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_code_nxt  = '0;
          w_count_nxt = '0;
        end else if (enter) begin
          if (r_count == MAX_DIGITS) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_code_nxt  = '0;
            w_count_nxt = '0;
            // Suppressed when error is already high so it never lasts 2 cycles.
            w_err_nxt   = !r_err;
          end
        end else if (w_digit_ok) begin
          w_code_nxt  = {r_code[CODE_W-DIGIT_W-1:0], digit};
          w_count_nxt = r_count + 3'd1;
        end
      end
      ST_CHECK: begin
        if (match) begin
          w_state_nxt = ST_OPEN;
          w_tries_nxt = '0;
        end else if (w_tries_inc >= TRY_LIMIT) begin
          w_state_nxt = ST_LOCKOUT;
          w_tmr_load  = 1'b1;
          w_code_nxt  = '0;
          w_count_nxt = '0;
        end else begin
          w_state_nxt = ST_FAIL;
          w_tries_nxt = w_tries_inc[2:0];
          w_code_nxt  = '0;
          w_count_nxt = '0;
          w_err_nxt   = 1'b1;
        end
      end
      ST_FAIL: w_state_nxt = ST_IDLE;
      ST_OPEN: begin
        if (clear || enter) begin
          w_state_nxt = ST_IDLE;
          w_code_nxt  = '0;
          w_count_nxt = '0;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_IDLE;
          w_tries_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign code        = r_code;
  assign digit_count = r_count;
  assign code_valid  = (r_state == ST_CHECK);
  assign unlocked    = (r_state == ST_OPEN);
  assign locked_out  = (r_state == ST_LOCKOUT);
  assign error       = r_err;

endmodule

// File: tb/tb_digilock_code_entry.sv
// Directed self-checking bench for digilock_code_entry (MAX_TRIES=3, LOCKOUT_CYCLES=16).
module tb_digilock_code_entry;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  digit = 4'h0;
  logic        digit_valid = 1'b0;
  logic        clear = 1'b0;
  logic        enter = 1'b0;
  logic        match = 1'b0;
  logic [15:0] code;
  logic        code_valid;
  logic [2:0]  digit_count;
  logic        unlocked;
  logic        error;
  logic        locked_out;

  int checks   = 0;
  int failures = 0;
  logic prev_err = 1'b0;

  always #5 clock = ~clock;

  digilock_code_entry #(.MAX_TRIES(3), .LOCKOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .digit       (digit),
    .digit_valid (digit_valid),
    .clear       (clear),
    .enter       (enter),
    .match       (match),
    .code        (code),
    .code_valid  (code_valid),
    .digit_count (digit_count),
    .unlocked    (unlocked),
    .error       (error),
    .locked_out  (locked_out)
  );

  // Cycle-by-cycle invariants on the status outputs.
  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if (error && prev_err) begin
        failures++;
        $display("FAIL err_consecutive: error high 2 cycles at %0t, required single pulse", $time);
      end
      checks++;
      if ($countones({unlocked, locked_out, code_valid}) > 1) begin
        failures++;
        $display("FAIL flags_exclusive: got u=%b l=%b v=%b, required at most one", unlocked, locked_out, code_valid);
      end
      prev_err = error;
    end else begin
      prev_err = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic key4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (code !== 16'h0) begin failures++; $display("FAIL reset_code: got %h exp 0000", code); end
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d exp 0", digit_count); end
    checks++; if ({code_valid, unlocked, error, locked_out} !== 4'b0) begin
      failures++; $display("FAIL reset_flags: got %b exp 0000", {code_valid, unlocked, error, locked_out});
    end
    reset_n = 1'b1;
    tick();
    checks++; if ({code_valid, unlocked, error, locked_out} !== 4'b0) begin
      failures++; $display("FAIL reset_release_flags: got %b exp 0000", {code_valid, unlocked, error, locked_out});
    end
  endtask

  task automatic test_unlock();
    match = 1'b1;
    key4(16'h1234);
    checks++; if (code !== 16'h1234) begin failures++; $display("FAIL unlock_code: got %h exp 1234", code); end
    checks++; if (digit_count !== 3'd4) begin failures++; $display("FAIL unlock_count: got %0d exp 4", digit_count); end
    pulse_enter();
    checks++; if (code_valid !== 1'b1 || unlocked !== 1'b0) begin
      failures++; $display("FAIL check_cycle: got valid=%b unlocked=%b exp valid=1 unlocked=0", code_valid, unlocked);
    end
    checks++; if (code !== 16'h1234) begin failures++; $display("FAIL check_code_hold: got %h exp 1234", code); end
    tick();
    checks++; if (code_valid !== 1'b0 || unlocked !== 1'b1) begin
      failures++; $display("FAIL open_state: got valid=%b unlocked=%b exp valid=0 unlocked=1", code_valid, unlocked);
    end
    press(4'h7);
    checks++; if (unlocked !== 1'b1 || code !== 16'h1234) begin
      failures++; $display("FAIL open_digit_ignored: got unlocked=%b code=%h exp 1 1234", unlocked, code);
    end
    pulse_clear();
    checks++; if (unlocked !== 1'b0 || code !== 16'h0 || digit_count !== 3'd0) begin
      failures++; $display("FAIL relock_clear: got unlocked=%b code=%h cnt=%0d exp 0 0000 0", unlocked, code, digit_count);
    end
    match = 1'b0;
  endtask

  task automatic test_short_entry();
    press(4'h1);
    press(4'h2);
    checks++; if (digit_count !== 3'd2) begin failures++; $display("FAIL short_count: got %0d exp 2", digit_count); end
    pulse_enter();
    checks++; if (error !== 1'b1 || code_valid !== 1'b0) begin
      failures++; $display("FAIL short_error: got error=%b valid=%b exp 1 0", error, code_valid);
    end
    checks++; if (code !== 16'h0 || digit_count !== 3'd0) begin
      failures++; $display("FAIL short_cleared: got code=%h cnt=%0d exp 0000 0", code, digit_count);
    end
    tick();
    checks++; if (error !== 1'b0 || code_valid !== 1'b0 || unlocked !== 1'b0) begin
      failures++; $display("FAIL short_after: got error=%b valid=%b unlocked=%b exp 000", error, code_valid, unlocked);
    end
  endtask

  task automatic test_lockout();
    int n;
    match = 1'b0;
    for (int r = 0; r < 2; r++) begin
      key4(16'h5678);
      pulse_enter();
      checks++; if (code_valid !== 1'b1) begin failures++; $display("FAIL wrong_check_%0d: got %b exp 1", r, code_valid); end
      tick();
      checks++; if (error !== 1'b1 || code !== 16'h0 || locked_out !== 1'b0) begin
        failures++; $display("FAIL wrong_fail_%0d: got err=%b code=%h lo=%b exp 1 0000 0", r, error, code, locked_out);
      end
      tick();
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL wrong_err_clear_%0d: got %b exp 0", r, error); end
    end
    key4(16'h5678);
    pulse_enter();
    tick();
    checks++; if (locked_out !== 1'b1 || error !== 1'b0 || code !== 16'h0) begin
      failures++; $display("FAIL lockout_entry: got lo=%b err=%b code=%h exp 1 0 0000", locked_out, error, code);
    end
    n = 0;
    while (locked_out && n < 40) begin
      n++;
      digit = 4'h3;
      digit_valid = 1'b1;
      enter = 1'b1;
      tick();
    end
    digit_valid = 1'b0;
    enter = 1'b0;
    checks++; if (n !== 16) begin failures++; $display("FAIL lockout_len: got %0d cycles exp 16", n); end
    checks++; if (code !== 16'h0 || digit_count !== 3'd0 || unlocked !== 1'b0) begin
      failures++; $display("FAIL lockout_ignored: got code=%h cnt=%0d unl=%b exp 0000 0 0", code, digit_count, unlocked);
    end
    key4(16'h1111);
    pulse_enter();
    tick();
    checks++; if (error !== 1'b1 || locked_out !== 1'b0) begin
      failures++; $display("FAIL tries_reset_lockout: got err=%b lo=%b exp 1 0", error, locked_out);
    end
    tick();
  endtask

  // tries=1 on entry: a correct code in between must reset the retry count.
  task automatic test_back_to_back();
    match = 1'b0;
    key4(16'h2222);
    pulse_enter();
    tick();
    tick();
    match = 1'b1;
    key4(16'h1234);
    pulse_enter();
    tick();
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL b2b_open: got %b exp 1", unlocked); end
    pulse_enter();
    checks++; if (unlocked !== 1'b0 || code !== 16'h0) begin
      failures++; $display("FAIL b2b_enter_relock: got unl=%b code=%h exp 0 0000", unlocked, code);
    end
    match = 1'b0;
    for (int r = 0; r < 2; r++) begin
      key4(16'h3333);
      pulse_enter();
      tick();
      checks++; if (error !== 1'b1 || locked_out !== 1'b0) begin
        failures++; $display("FAIL b2b_tries_reset_%0d: got err=%b lo=%b exp 1 0", r, error, locked_out);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    key4(16'h1234);
    press(4'h5);
    checks++; if (code !== 16'h1234 || digit_count !== 3'd4) begin
      failures++; $display("FAIL fifth_digit: got code=%h cnt=%0d exp 1234 4", code, digit_count);
    end
    pulse_clear();
    press(4'hA);
    press(4'hF);
    checks++; if (code !== 16'h0 || digit_count !== 3'd0) begin
      failures++; $display("FAIL non_bcd: got code=%h cnt=%0d exp 0000 0", code, digit_count);
    end
    press(4'h9);
    checks++; if (code !== 16'h0009 || digit_count !== 3'd1) begin
      failures++; $display("FAIL digit_nine: got code=%h cnt=%0d exp 0009 1", code, digit_count);
    end
    pulse_clear();
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL idle_clear: got %0d exp 0", digit_count); end
  endtask

  task automatic test_priority();
    key4(16'h1234);
    clear = 1'b1;
    enter = 1'b1;
    digit = 4'h5;
    digit_valid = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    digit_valid = 1'b0;
    checks++; if (code !== 16'h0 || digit_count !== 3'd0 || code_valid !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL prio_clear: got code=%h cnt=%0d v=%b e=%b exp 0000 0 0 0", code, digit_count, code_valid, error);
    end
    tick();
    checks++; if (code_valid !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL prio_no_check: got v=%b e=%b exp 0 0", code_valid, error);
    end
    press(4'h1);
    press(4'h2);
    enter = 1'b1;
    digit = 4'h3;
    digit_valid = 1'b1;
    tick();
    enter = 1'b0;
    digit_valid = 1'b0;
    checks++; if (error !== 1'b1 || digit_count !== 3'd0 || code !== 16'h0) begin
      failures++; $display("FAIL prio_enter_over_digit: got e=%b cnt=%0d code=%h exp 1 0 0000", error, digit_count, code);
    end
    tick();
  endtask

  task automatic test_reset_in_lockout();
    match = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    for (int r = 0; r < 2; r++) begin
      key4(16'h9999);
      pulse_enter();
      tick();
      tick();
    end
    key4(16'h9999);
    pulse_enter();
    tick();
    checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL rst_lo_enter: got %b exp 1", locked_out); end
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({locked_out, unlocked, error, code_valid} !== 4'b0 || code !== 16'h0 || digit_count !== 3'd0) begin
      failures++; $display("FAIL rst_async: got flags=%b code=%h cnt=%0d exp 0000 0000 0",
                           {locked_out, unlocked, error, code_valid}, code, digit_count);
    end
    #2;
    reset_n = 1'b1;
    tick();
    checks++; if (error !== 1'b0 || locked_out !== 1'b0) begin
      failures++; $display("FAIL rst_release: got err=%b lo=%b exp 0 0", error, locked_out);
    end
    match = 1'b1;
    key4(16'h4321);
    pulse_enter();
    tick();
    checks++; if (unlocked !== 1'b1 || code !== 16'h4321) begin
      failures++; $display("FAIL rst_then_unlock: got unl=%b code=%h exp 1 4321", unlocked, code);
    end
    pulse_clear();
    match = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_short_entry();
    test_lockout();
    test_back_to_back();
    test_overflow();
    test_priority();
    test_reset_in_lockout();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
